pipelined_addsub: RTL

- Parametrised successor of the single-cycle combinational adder.
- Chunked, pipelined adder/subtractor: carry ripples across STAGES register stages, one chunk per stage.
- Adds subtract and signed-saturating modes, carry/overflow/zero flags, and a valid/ready handshake with backpressure.
- Serves as the integer add/sub unit for multi-cycle datapath variants; the combinational adder stays in the PC-increment path.

---
 rtl/pipelined_addsub.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pipelined_addsub.sv
// Chunked, pipelined adder/subtractor with signed saturation, carry/overflow/zero flags
// and a valid/ready handshake. Carry ripples one CHUNK per register stage.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // op[0] selects subtract (invert B, carry-in 1); op[1] selects saturation.
  logic              ready_q;
  logic [STAGES-1:0] v_q, v_n;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              c_q [STAGES];
  logic [1:0]        op_q[STAGES];
  logic [WIDTH-1:0]  a_n [STAGES];
  logic [WIDTH-1:0]  b_n [STAGES];
  logic [WIDTH-1:0]  s_n [STAGES];
  logic              c_n [STAGES];
  logic [1:0]        op_n[STAGES];

  logic adv;
  logic accept;

  assign adv      = !v_q[LAST] || out_ready;
  assign in_ready = ready_q && adv;
  assign accept   = in_valid && in_ready;

  // Every stage computes its chunk from the previous stage's registers; stage 0 from the ports.
  always_comb begin
    logic [WIDTH-1:0] pa, pb, ps;
    logic             pc;
    logic [1:0]       po;
    logic [CHUNK:0]   t;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        pa = A;
        pb = op[0] ? ~B : B;
        ps = '0;
        pc = op[0];
        po = op;
        v_n[k] = accept;
      end else begin
        pa = a_q[(k == 0) ? 0 : k - 1];
        pb = b_q[(k == 0) ? 0 : k - 1];
        ps = s_q[(k == 0) ? 0 : k - 1];
        pc = c_q[(k == 0) ? 0 : k - 1];
        po = op_q[(k == 0) ? 0 : k - 1];
        v_n[k] = v_q[(k == 0) ? 0 : k - 1];
      end
      t = {1'b0, pa[k*CHUNK +: CHUNK]} + {1'b0, pb[k*CHUNK +: CHUNK]}
        + {{CHUNK{1'b0}}, pc};
      s_n[k] = ps;
      s_n[k][k*CHUNK +: CHUNK] = t[CHUNK-1:0];
      c_n[k]  = t[CHUNK];
      a_n[k]  = pa;
      b_n[k]  = pb;
      op_n[k] = po;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q <= 1'b0;
      v_q     <= '0;
    end else begin
      ready_q <= 1'b1;
      if (adv) v_q <= v_n;
    end
  end

  // NOTE: datapath registers have no reset; the valid bits alone qualify their contents,
  // and the outputs below are gated by out_valid so they read 0 during reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= a_n[k];
        b_q[k]  <= b_n[k];
        s_q[k]  <= s_n[k];
        c_q[k]  <= c_n[k];
        op_q[k] <= op_n[k];
      end
    end
  end

  logic             msb_a, msb_b, ovf;
  logic [WIDTH-1:0] raw, sat_val, res;

  always_comb begin
    msb_a   = a_q[LAST][WIDTH-1];
    msb_b   = b_q[LAST][WIDTH-1];
    raw     = s_q[LAST];
    ovf     = (msb_a == msb_b) && (raw[WIDTH-1] != msb_a);
    sat_val = msb_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    res     = (op_q[LAST][1] && ovf) ? sat_val : raw;
  end

  assign out_valid = v_q[LAST];
  assign out       = out_valid ? res : '0;
  assign carry     = out_valid && c_q[LAST];
  assign overflow  = out_valid && ovf;
  assign zero      = out_valid && (res == '0);

endmodule
